// File: rtl/ramio_pkg.sv
// Shared types and constants for the core ramio port to cache/IO bridge.
package ramio_pkg;
  typedef enum logic [2:0] {Idle, CacheReq, CacheRsp, UartTx, Done} state_e;

  localparam logic [1:0] WriteNone = 2'b00;
  localparam logic [1:0] WriteByte = 2'b01;
  localparam logic [1:0] WriteHalf = 2'b10;
  localparam logic [1:0] WriteWord = 2'b11;

  // Size field of read_type; bit ReadSignBit selects sign extension.
  localparam logic [1:0] ReadNone    = 2'b00;
  localparam logic [1:0] ReadByte    = 2'b01;
  localparam logic [1:0] ReadHalf    = 2'b10;
  localparam int         ReadSignBit = 2;

  localparam logic [31:0] LedAddr    = 32'hFFFF_FFFC;
  localparam logic [31:0] UartTxAddr = 32'hFFFF_FFF8;
  localparam logic [31:0] UartRxAddr = 32'hFFFF_FFF4;
endpackage

// File: rtl/ramio_align.sv
// Lane steering: store data/byte enables toward the cache, load extraction/extension back.
module ramio_align
  import ramio_pkg::*;
(
  input  logic [1:0]  i_wr_lo,
  input  logic [1:0]  i_wr_type,
  input  logic [31:0] i_wr_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wr_lane,
  input  logic [1:0]  i_rd_lo,
  input  logic [2:0]  i_rd_type,
  input  logic [31:0] i_rd_raw,
  output logic [31:0] o_rd_ext
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sgn;

  always_comb begin
    o_be      = 4'b1111;
    o_wr_lane = i_wr_data;
    case (i_wr_type)
      WriteByte: begin
        o_be      = 4'b0001 << i_wr_lo;
        o_wr_lane = {4{i_wr_data[7:0]}};
      end
      WriteHalf: begin
        o_be      = i_wr_lo[1] ? 4'b1100 : 4'b0011;
        o_wr_lane = {2{i_wr_data[15:0]}};
      end
      WriteWord: o_be = 4'b1111;
      default:   o_be = 4'b1111;
    endcase
  end

  // Misaligned halves/words simply ignore the low address bits.
  assign w_byte = i_rd_raw[{i_rd_lo, 3'b000} +: 8];
  assign w_half = i_rd_lo[1] ? i_rd_raw[31:16] : i_rd_raw[15:0];
  assign w_sgn  = i_rd_type[ReadSignBit];

  always_comb begin
    o_rd_ext = i_rd_raw;
    case (i_rd_type[1:0])
      ReadByte: o_rd_ext = {{24{w_sgn & w_byte[7]}}, w_byte};
      ReadHalf: o_rd_ext = {{16{w_sgn & w_half[15]}}, w_half};
      default:  o_rd_ext = i_rd_raw;
    endcase
  end
endmodule

// File: rtl/ramio_bridge.sv
// Bridges the core ramio port to a word-wide cache and a small IO window (LEDs, UART).
module ramio_bridge
  import ramio_pkg::*;
#(
  parameter logic [31:0] IoBase   = 32'hFFFF_FFF0,
  parameter int          LedWidth = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ramio_enable,
  input  logic [1:0]          ramio_write_type,
  input  logic [2:0]          ramio_read_type,
  input  logic [31:0]         ramio_address,
  input  logic [31:0]         ramio_data_in,
  output logic [31:0]         ramio_data_out,
  output logic                ramio_data_out_ready,
  output logic                ramio_busy,
  output logic                cache_req_valid,
  input  logic                cache_req_ready,
  output logic [31:0]         cache_address,
  output logic [3:0]          cache_write_enable,
  output logic [31:0]         cache_data_in,
  input  logic                cache_rsp_valid,
  input  logic [31:0]         cache_data_out,
  output logic [LedWidth-1:0] led,
  output logic [7:0]          uart_tx_data,
  output logic                uart_tx_go,
  input  logic                uart_tx_busy,
  input  logic [7:0]          uart_rx_data,
  input  logic                uart_rx_data_ready,
  output logic                uart_rx_ack
);
  state_e      r_state;
  logic [31:0] r_addr;
  logic [2:0]  r_rt;
  logic [1:0]  r_wt;
  logic [7:0]  r_data;

  logic        w_new_req, w_new_wr, w_is_io, w_changed, w_can_accept, w_lat_read;
  logic [31:0] w_io_word, w_io_rdata, w_lane, w_rd_ext;
  logic [3:0]  w_be;

  assign w_new_wr     = ramio_write_type != WriteNone;
  assign w_new_req    = ramio_enable && (w_new_wr || ramio_read_type[1:0] != ReadNone);
  assign w_is_io      = ramio_address >= IoBase;
  assign w_io_word    = {ramio_address[31:2], 2'b00};
  assign w_changed    = !ramio_enable ||
                        ({ramio_address, ramio_read_type, ramio_write_type} != {r_addr, r_rt, r_wt});
  assign w_can_accept = (r_state == Idle) || (r_state == Done && w_changed);
  assign w_lat_read   = (r_wt == WriteNone) && (r_rt[1:0] != ReadNone);

  assign ramio_data_out_ready = (r_state == Done) && w_lat_read && !w_changed;
  assign ramio_busy = (r_state != Idle && r_state != Done) ||
                      (ramio_enable && w_new_wr && !(r_state == Done && !w_changed));

  always_comb begin
    w_io_rdata = 32'h0;
    case (w_io_word)
      LedAddr:    w_io_rdata = {{(32-LedWidth){1'b0}}, led};
      UartTxAddr: w_io_rdata = {31'h0, uart_tx_busy};
      UartRxAddr: w_io_rdata = uart_rx_data_ready ? {24'h0, uart_rx_data} : 32'hFFFF_FFFF;
      default:    w_io_rdata = 32'h0;
    endcase
  end

  ramio_align u_align (
    .i_wr_lo   (ramio_address[1:0]),
    .i_wr_type (ramio_write_type),
    .i_wr_data (ramio_data_in),
    .o_be      (w_be),
    .o_wr_lane (w_lane),
    .i_rd_lo   (r_addr[1:0]),
    .i_rd_type (r_rt),
    .i_rd_raw  (cache_data_out),
    .o_rd_ext  (w_rd_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= Idle;
      r_addr             <= 32'h0;
      r_rt               <= 3'b000;
      r_wt               <= WriteNone;
      r_data             <= 8'h0;
      cache_req_valid    <= 1'b0;
      cache_address      <= 32'h0;
      cache_write_enable <= 4'b0000;
      cache_data_in      <= 32'h0;
      led                <= '0;
      uart_tx_data       <= 8'h0;
      uart_tx_go         <= 1'b0;
      uart_rx_ack        <= 1'b0;
      ramio_data_out     <= 32'h0;
    end else begin
      uart_tx_go  <= 1'b0;
      uart_rx_ack <= 1'b0;
      if (w_can_accept) begin
        if (w_new_req) begin
          r_addr <= ramio_address;
          r_rt   <= ramio_read_type;
          r_wt   <= ramio_write_type;
          r_data <= ramio_data_in[7:0];
          if (!w_is_io) begin
            r_state            <= CacheReq;
            cache_req_valid    <= 1'b1;
            cache_address      <= w_io_word;
            cache_write_enable <= w_new_wr ? w_be : 4'b0000;
            cache_data_in      <= w_lane;
          end else if (w_new_wr && w_io_word == UartTxAddr) begin
            r_state <= UartTx;
          end else begin
            // Remaining IO operations finish in the acceptance cycle.
            r_state <= Done;
            if (w_new_wr) begin
              if (w_io_word == LedAddr) led <= ramio_data_in[LedWidth-1:0];
            end else begin
              ramio_data_out <= w_io_rdata;
              uart_rx_ack    <= (w_io_word == UartRxAddr) && uart_rx_data_ready;
            end
          end
        end else begin
          r_state <= Idle;
        end
      end else begin
        case (r_state)
          CacheReq: if (cache_req_ready) begin
            cache_req_valid <= 1'b0;
            r_state         <= (r_wt != WriteNone) ? Done : CacheRsp;
          end
          CacheRsp: if (cache_rsp_valid) begin
            ramio_data_out <= w_rd_ext;
            r_state        <= Done;
          end
          UartTx: if (!uart_tx_busy) begin
            uart_tx_data <= r_data;
            uart_tx_go   <= 1'b1;
            r_state      <= Done;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ramio_bridge.sv
// Directed bench for ramio_bridge: cache stores/loads, fetch reuse, UART, LED and reset.
module tb_ramio_bridge;
  logic        clk = 1'b0, rst = 1'b1;
  logic        ramio_enable = 1'b0;
  logic [1:0]  ramio_write_type = 2'b00;
  logic [2:0]  ramio_read_type = 3'b000;
  logic [31:0] ramio_address = 32'h0, ramio_data_in = 32'h0;
  logic [31:0] ramio_data_out;
  logic        ramio_data_out_ready, ramio_busy;
  logic        cache_req_valid, cache_req_ready = 1'b1;
  logic [31:0] cache_address, cache_data_in;
  logic [3:0]  cache_write_enable;
  logic        cache_rsp_valid = 1'b0;
  logic [31:0] cache_data_out = 32'h0;
  logic [5:0]  led;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_go, uart_tx_busy = 1'b0;
  logic [7:0]  uart_rx_data = 8'h0;
  logic        uart_rx_data_ready = 1'b0, uart_rx_ack;

  int total = 0, bad = 0;
  int n_req = 0, n_go = 0, n_ack = 0;
  int base;
  logic        pend = 1'b0, rsp_hold = 1'b0;
  logic [31:0] mem_word = 32'h0;

  ramio_bridge #(.IoBase(32'hFFFF_FFF0), .LedWidth(6)) dut (
    .clk(clk), .rst(rst),
    .ramio_enable(ramio_enable), .ramio_write_type(ramio_write_type),
    .ramio_read_type(ramio_read_type), .ramio_address(ramio_address),
    .ramio_data_in(ramio_data_in), .ramio_data_out(ramio_data_out),
    .ramio_data_out_ready(ramio_data_out_ready), .ramio_busy(ramio_busy),
    .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready),
    .cache_address(cache_address), .cache_write_enable(cache_write_enable),
    .cache_data_in(cache_data_in), .cache_rsp_valid(cache_rsp_valid),
    .cache_data_out(cache_data_out), .led(led),
    .uart_tx_data(uart_tx_data), .uart_tx_go(uart_tx_go), .uart_tx_busy(uart_tx_busy),
    .uart_rx_data(uart_rx_data), .uart_rx_data_ready(uart_rx_data_ready),
    .uart_rx_ack(uart_rx_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && cache_req_valid && cache_req_ready) n_req++;
    if (uart_tx_go) n_go++;
    if (uart_rx_ack) n_ack++;
  end

  // Cache model: answers a read one cycle after its handshake.
  always @(negedge clk) begin
    cache_rsp_valid = 1'b0;
    if (rst) pend = 1'b0;
    else begin
      if (pend) begin
        cache_rsp_valid = 1'b1;
        cache_data_out  = mem_word;
        pend            = 1'b0;
      end
      if (cache_req_valid && cache_req_ready && cache_write_enable == 4'b0000 && !rsp_hold)
        pend = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic req(input logic en, input logic [1:0] wt, input logic [2:0] rt,
                     input logic [31:0] addr, input logic [31:0] data);
    ramio_enable     = en;
    ramio_write_type = wt;
    ramio_read_type  = rt;
    ramio_address    = addr;
    ramio_data_in    = data;
    #1;
  endtask

  task automatic wait_ready(input string tag, input int exp_cyc);
    int c = 0;
    while (!ramio_data_out_ready && c < 20) begin
      tick();
      c++;
    end
    chk({tag, "_lat"}, c, exp_cyc);
  endtask

  initial begin
    // reset state
    tick(2);
    chk("rst_valid", {31'h0, cache_req_valid}, 32'h0);
    chk("rst_we", {28'h0, cache_write_enable}, 32'h0);
    chk("rst_led", {26'h0, led}, 32'h0);
    chk("rst_dout", ramio_data_out, 32'h0);
    chk("rst_go_ack", {30'h0, uart_tx_go, uart_rx_ack}, 32'h0);
    chk("rst_busy", {31'h0, ramio_busy}, 32'h0);
    rst = 1'b0;
    tick();

    // SB 0xAB to 0x102 with the cache stalling
    cache_req_ready = 1'b0;
    req(1, 2'b01, 3'b000, 32'h0000_0102, 32'h0000_00AB);
    chk("sb_busy_acc", {31'h0, ramio_busy}, 32'h1);
    tick();
    chk("sb_valid", {31'h0, cache_req_valid}, 32'h1);
    chk("sb_we", {28'h0, cache_write_enable}, 32'h4);
    chk("sb_data", cache_data_in, 32'hABAB_ABAB);
    chk("sb_addr", cache_address, 32'h0000_0100);
    tick();
    chk("sb_busy_stall", {31'h0, ramio_busy}, 32'h1);
    chk("sb_valid_stall", {31'h0, cache_req_valid}, 32'h1);
    cache_req_ready = 1'b1;
    tick();
    chk("sb_valid_done", {31'h0, cache_req_valid}, 32'h0);
    chk("sb_busy_done", {31'h0, ramio_busy}, 32'h0);
    req(0, 2'b00, 3'b000, 32'h0, 32'h0);
    tick();

    // SH 0x1234 to 0x106
    req(1, 2'b10, 3'b000, 32'h0000_0106, 32'h0000_1234);
    tick();
    chk("sh_we", {28'h0, cache_write_enable}, 32'hC);
    chk("sh_data", cache_data_in, 32'h1234_1234);
    chk("sh_addr", cache_address, 32'h0000_0104);
    req(0, 2'b00, 3'b000, 32'h0, 32'h0);
    tick(2);

    // loads with extension from word 0x80FF_7F01
    mem_word = 32'h80FF_7F01;
    req(1, 2'b00, 3'b101, 32'h0000_0201, 32'h0);
    wait_ready("lb201", 3);
    chk("lb201", ramio_data_out, 32'h0000_007F);
    req(0, 2'b00, 3'b000, 32'h0, 32'h0); tick();
    req(1, 2'b00, 3'b101, 32'h0000_0203, 32'h0);
    wait_ready("lb203", 3);
    chk("lb203", ramio_data_out, 32'hFFFF_FF80);
    req(0, 2'b00, 3'b000, 32'h0, 32'h0); tick();
    req(1, 2'b00, 3'b010, 32'h0000_0202, 32'h0);
    wait_ready("lhu202", 3);
    chk("lhu202", ramio_data_out, 32'h0000_80FF);
    req(0, 2'b00, 3'b000, 32'h0, 32'h0); tick();
    req(1, 2'b00, 3'b011, 32'h0000_0200, 32'h0);
    wait_ready("lw200", 3);
    chk("lw200", ramio_data_out, 32'h80FF_7F01);
    req(0, 2'b00, 3'b000, 32'h0, 32'h0); tick();

    // back-to-back fetches 0x0, 0x4, 0x4 held, 0x8
    mem_word = 32'h0000_0013;
    base = n_req;
    req(1, 2'b00, 3'b011, 32'h0000_0000, 32'h0);
    wait_ready("f0", 3);
    req(1, 2'b00, 3'b011, 32'h0000_0004, 32'h0);
    chk("f4_rdy_chg", {31'h0, ramio_data_out_ready}, 32'h0);
    wait_ready("f4", 3);
    tick(3);
    chk("f4_held_rdy", {31'h0, ramio_data_out_ready}, 32'h1);
    chk("f4_held_data", ramio_data_out, 32'h0000_0013);
    req(1, 2'b00, 3'b011, 32'h0000_0008, 32'h0);
    chk("f8_rdy_chg", {31'h0, ramio_data_out_ready}, 32'h0);
    wait_ready("f8", 3);
    req(0, 2'b00, 3'b000, 32'h0, 32'h0); tick();
    chk("fetch_reqs", n_req - base, 32'd3);

    // UART tx with transmitter busy for 5 cycles
    base = n_go;
    uart_tx_busy = 1'b1;
    req(1, 2'b11, 3'b000, 32'hFFFF_FFF8, 32'h0000_0041);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("tx_busy_hold", {31'h0, ramio_busy}, 32'h1);
      chk("tx_no_go", {31'h0, uart_tx_go}, 32'h0);
    end
    uart_tx_busy = 1'b0;
    tick();
    chk("tx_go", {31'h0, uart_tx_go}, 32'h1);
    chk("tx_data", {24'h0, uart_tx_data}, 32'h41);
    chk("tx_busy_done", {31'h0, ramio_busy}, 32'h0);
    tick();
    chk("tx_go_once", {31'h0, uart_tx_go}, 32'h0);
    req(0, 2'b00, 3'b000, 32'h0, 32'h0); tick();
    chk("tx_go_count", n_go - base, 32'd1);

    // LED write/read-back
    req(1, 2'b11, 3'b000, 32'hFFFF_FFFC, 32'h0000_002A);
    tick();
    chk("led_wr", {26'h0, led}, 32'h2A);
    req(0, 2'b00, 3'b000, 32'h0, 32'h0); tick();
    req(1, 2'b00, 3'b011, 32'hFFFF_FFFC, 32'h0);
    wait_ready("led_rd", 1);
    chk("led_rd", ramio_data_out, 32'h0000_002A);
    req(0, 2'b00, 3'b000, 32'h0, 32'h0); tick();

    // UART rx: empty then one byte
    base = n_ack;
    req(1, 2'b00, 3'b011, 32'hFFFF_FFF4, 32'h0);
    wait_ready("rx_empty", 1);
    chk("rx_empty", ramio_data_out, 32'hFFFF_FFFF);
    chk("rx_empty_ack", {31'h0, uart_rx_ack}, 32'h0);
    req(0, 2'b00, 3'b000, 32'h0, 32'h0); tick();
    uart_rx_data_ready = 1'b1;
    uart_rx_data = 8'h55;
    req(1, 2'b00, 3'b011, 32'hFFFF_FFF4, 32'h0);
    wait_ready("rx_data", 1);
    chk("rx_data", ramio_data_out, 32'h0000_0055);
    chk("rx_ack", {31'h0, uart_rx_ack}, 32'h1);
    tick();
    chk("rx_ack_once", {31'h0, uart_rx_ack}, 32'h0);
    req(0, 2'b00, 3'b000, 32'h0, 32'h0); tick();
    chk("rx_ack_count", n_ack - base, 32'd1);
    uart_rx_data_ready = 1'b0;

    // unmapped IO address reads zero
    req(1, 2'b00, 3'b011, 32'hFFFF_FFF0, 32'h0);
    wait_ready("io_other", 1);
    chk("io_other", ramio_data_out, 32'h0);
    req(0, 2'b00, 3'b000, 32'h0, 32'h0); tick();

    // reset while waiting in CacheRsp, then a normal read
    ramio_data_in = 32'h0;
    uart_rx_data_ready = 1'b1;
    req(1, 2'b00, 3'b011, 32'hFFFF_FFF4, 32'h0);
    tick();
    req(0, 2'b00, 3'b000, 32'h0, 32'h0); tick();
    uart_rx_data_ready = 1'b0;
    mem_word = 32'h80FF_7F01;
    rsp_hold = 1'b1;
    req(1, 2'b00, 3'b011, 32'h0000_0200, 32'h0);
    tick(3);
    chk("rsp_wait_busy", {31'h0, ramio_busy}, 32'h1);
    chk("rsp_wait_rdy", {31'h0, ramio_data_out_ready}, 32'h0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'h0, cache_req_valid}, 32'h0);
    chk("mid_rst_led", {26'h0, led}, 32'h0);
    chk("mid_rst_dout", ramio_data_out, 32'h0);
    chk("mid_rst_busy", {31'h0, ramio_busy}, 32'h0);
    tick();
    rst = 1'b0;
    rsp_hold = 1'b0;
    #1;
    wait_ready("post_rst", 3);
    chk("post_rst_lw", ramio_data_out, 32'h80FF_7F01);
    req(0, 2'b00, 3'b000, 32'h0, 32'h0); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
